// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cpu inst/data request ports plus the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    inst_read;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic                    inst_resp;
  logic [DATA_WIDTH-1:0]   inst_rdata;
  logic                    data_read;
  logic                    data_write;
  logic [DATA_WIDTH/8-1:0] data_mbe;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic                    data_resp;
  logic [DATA_WIDTH-1:0]   data_rdata;
  logic                    mem_read;
  logic                    mem_write;
  logic [DATA_WIDTH/8-1:0] mem_mbe;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_resp;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    busy;
  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata, mem_resp, mem_rdata,
    output inst_resp, inst_rdata, data_resp, data_rdata, mem_read, mem_write, mem_mbe, mem_addr, mem_wdata, busy
  );
  modport master (
    output inst_read, inst_addr, data_read, data_write, data_mbe, data_addr, data_wdata, mem_resp, mem_rdata,
    input  inst_resp, inst_rdata, data_resp, data_rdata, mem_read, mem_write, mem_mbe, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data load/store
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_POLICY = 0
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  state_t state, state_nxt;
  logic last_data;
  logic data_req, grant_data, grant_inst, done;
  assign data_req = bus.data_read | bus.data_write;
  assign done = (state != IDLE) & bus.mem_resp;
  // arbitration and next state; a tie goes to data under fixed priority or when inst won last
  always_comb begin
    grant_data = (state == IDLE) && data_req && (!bus.inst_read || ARB_POLICY == 1 || !last_data);
    grant_inst = (state == IDLE) && bus.inst_read && !grant_data;
    state_nxt  = grant_data ? DATA : grant_inst ? INST : done ? IDLE : state;
  end
  // state register and last-grant memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_data <= grant_data ? 1'b1 : grant_inst ? 1'b0 : last_data;
    end
  end
  // registered downstream command, held until the memory completes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_mbe   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (grant_inst) begin
      bus.mem_read  <= 1'b1;
      bus.mem_write <= 1'b0;
      bus.mem_mbe   <= '1;
      bus.mem_addr  <= bus.inst_addr;
    end else if (grant_data) begin
      bus.mem_read  <= bus.data_read & ~bus.data_write;
      bus.mem_write <= bus.data_write;
      bus.mem_mbe   <= bus.data_mbe;
      bus.mem_addr  <= bus.data_addr;
      bus.mem_wdata <= bus.data_wdata;
    end else if (done) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end
  end
  // simultaneous data read and write is a requester bug; write wins in hardware
  always_ff @(posedge clk) begin
    if (!rst) assert (!(bus.data_read && bus.data_write));
  end
  // completion pulses follow mem_resp for the granted side only; read data passes straight through
  always_comb begin
    bus.busy       = state != IDLE;
    bus.inst_resp  = (state == INST) & bus.mem_resp;
    bus.data_resp  = (state == DATA) & bus.mem_resp;
    bus.inst_rdata = bus.mem_rdata;
    bus.data_rdata = bus.mem_rdata;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard-driven checks of both arbitration policies
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_POLICY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_POLICY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  typedef struct packed {logic is_data; logic [31:0] addr;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    b0.inst_read = 0; b0.inst_addr = 0; b0.data_read = 0; b0.data_write = 0; b0.data_mbe = 0;
    b0.data_addr = 0; b0.data_wdata = 0; b0.mem_resp = 0; b0.mem_rdata = 0;
    b1.inst_read = 0; b1.inst_addr = 0; b1.data_read = 0; b1.data_write = 0; b1.data_mbe = 0;
    b1.data_addr = 0; b1.data_wdata = 0; b1.mem_resp = 0; b1.mem_rdata = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    clear_inputs();
    repeat (2) tick();
    checks++; if ({b0.mem_read, b0.mem_write, b0.busy, b0.inst_resp, b0.data_resp} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {b0.mem_read, b0.mem_write, b0.busy, b0.inst_resp, b0.data_resp}); end
    checks++; if ({b0.mem_mbe, b0.mem_addr, b0.mem_wdata} !== 68'h0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {b0.mem_mbe, b0.mem_addr, b0.mem_wdata}); end
    checks++; if ({b1.mem_read, b1.mem_write, b1.busy} !== 3'b0) begin errors++; $display("FAIL reset_ctrl_p1: got %b expected 000", {b1.mem_read, b1.mem_write, b1.busy}); end
    rst = 0;
  endtask

  task automatic test_inst_read;
    exp_t e;
    b0.inst_addr = 32'h60; b0.inst_read = 1;
    sb.push_back('{1'b0, 32'h60});
    tick();
    e = sb.pop_front();
    checks++; if ({b0.mem_read, b0.mem_write} !== 2'b10) begin errors++; $display("FAIL inst_cmd: got %b expected 10", {b0.mem_read, b0.mem_write}); end
    checks++; if (b0.mem_addr !== e.addr) begin errors++; $display("FAIL inst_addr: got %h expected %h", b0.mem_addr, e.addr); end
    checks++; if (b0.mem_mbe !== 4'hF) begin errors++; $display("FAIL inst_mbe: got %h expected f", b0.mem_mbe); end
    checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL inst_busy: got %b expected 1", b0.busy); end
    b0.mem_rdata = 32'h13; b0.mem_resp = 1;
    #1;
    checks++; if ({b0.inst_resp, b0.data_resp} !== 2'b10) begin errors++; $display("FAIL inst_resp: got %b expected 10", {b0.inst_resp, b0.data_resp}); end
    checks++; if (b0.inst_rdata !== 32'h13) begin errors++; $display("FAIL inst_rdata: got %h expected 00000013", b0.inst_rdata); end
    tick();
    b0.mem_resp = 0; b0.inst_read = 0;
    checks++; if ({b0.mem_read, b0.busy} !== 2'b00) begin errors++; $display("FAIL inst_done: got %b expected 00", {b0.mem_read, b0.busy}); end
    b0.mem_resp = 1;
    #1;
    checks++; if ({b0.inst_resp, b0.data_resp} !== 2'b00) begin errors++; $display("FAIL idle_resp: got %b expected 00", {b0.inst_resp, b0.data_resp}); end
    tick();
    b0.mem_resp = 0;
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", b0.busy); end
  endtask

  task automatic test_data_write;
    exp_t e;
    int pulses;
    logic stable;
    b0.data_addr = 32'h100; b0.data_wdata = 32'hDEADBEEF; b0.data_mbe = 4'b0011; b0.data_write = 1;
    sb.push_back('{1'b1, 32'h100});
    tick();
    e = sb.pop_front();
    checks++; if ({b0.mem_read, b0.mem_write} !== 2'b01) begin errors++; $display("FAIL dw_cmd: got %b expected 01", {b0.mem_read, b0.mem_write}); end
    checks++; if (b0.mem_addr !== e.addr) begin errors++; $display("FAIL dw_addr: got %h expected %h", b0.mem_addr, e.addr); end
    checks++; if (b0.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dw_wdata: got %h expected deadbeef", b0.mem_wdata); end
    checks++; if (b0.mem_mbe !== 4'b0011) begin errors++; $display("FAIL dw_mbe: got %b expected 0011", b0.mem_mbe); end
    pulses = 0; stable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b0.mem_addr !== e.addr || b0.mem_write !== 1'b1 || b0.mem_wdata !== 32'hDEADBEEF) stable = 0;
      if (b0.data_resp === 1'b1) pulses++;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL dw_hold: got %b expected 1", stable); end
    b0.mem_resp = 1;
    #1;
    if (b0.data_resp === 1'b1) pulses++;
    tick();
    b0.mem_resp = 0; b0.data_write = 0;
    #1;
    if (b0.data_resp === 1'b1) pulses++;
    tick();
    if (b0.data_resp === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL dw_pulses: got %0d expected 1", pulses); end
    checks++; if ({b0.mem_write, b0.busy} !== 2'b00) begin errors++; $display("FAIL dw_done: got %b expected 00", {b0.mem_write, b0.busy}); end
  endtask

  task automatic test_mid_request;
    exp_t e;
    logic stable;
    b0.data_addr = 32'h200; b0.data_read = 1;
    sb.push_back('{1'b1, 32'h200});
    sb.push_back('{1'b0, 32'h300});
    tick();
    e = sb.pop_front();
    checks++; if (b0.mem_read !== 1'b1 || b0.mem_addr !== e.addr) begin errors++; $display("FAIL mid_first: got %b/%h expected 1/%h", b0.mem_read, b0.mem_addr, e.addr); end
    b0.inst_addr = 32'h300; b0.inst_read = 1;
    stable = 1;
    repeat (3) begin
      tick();
      if (b0.mem_addr !== e.addr || b0.busy !== 1'b1) stable = 0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL mid_hold: got %b expected 1", stable); end
    b0.mem_rdata = 32'hA5A5_0001; b0.mem_resp = 1;
    #1;
    checks++; if ({b0.data_resp, b0.inst_resp} !== 2'b10 || b0.data_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL mid_resp: got %b/%h expected 10/a5a50001", {b0.data_resp, b0.inst_resp}, b0.data_rdata); end
    tick();
    b0.mem_resp = 0; b0.data_read = 0;
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL mid_turnaround: got %b expected 0", b0.busy); end
    tick();
    e = sb.pop_front();
    checks++; if (b0.mem_read !== 1'b1 || b0.mem_addr !== e.addr || b0.busy !== 1'b1) begin errors++; $display("FAIL mid_inst_grant: got %b/%h expected 1/%h", b0.mem_read, b0.mem_addr, e.addr); end
    b0.mem_resp = 1;
    #1;
    checks++; if ({b0.inst_resp, b0.data_resp} !== 2'b10) begin errors++; $display("FAIL mid_inst_resp: got %b expected 10", {b0.inst_resp, b0.data_resp}); end
    tick();
    b0.mem_resp = 0; b0.inst_read = 0;
    tick();
  endtask

  task automatic test_round_robin;
    exp_t e;
    int idle, budget;
    rst = 1; tick(); rst = 0;
    b0.inst_addr = 32'h40; b0.data_addr = 32'h80; b0.inst_read = 1; b0.data_read = 1;
    sb.push_back('{1'b1, 32'h80}); sb.push_back('{1'b0, 32'h40});
    sb.push_back('{1'b1, 32'h80}); sb.push_back('{1'b0, 32'h40});
    idle = 1; budget = 0;
    while (sb.size() > 0 && budget < 60) begin
      tick(); budget++;
      if (!b0.busy) idle++;
      else begin
        e = sb.pop_front();
        checks++; if (b0.mem_addr !== e.addr || b0.mem_read !== 1'b1) begin errors++; $display("FAIL rr_order: got %b/%h expected 1/%h", b0.mem_read, b0.mem_addr, e.addr); end
        checks++; if (idle < 1) begin errors++; $display("FAIL rr_gap: got %0d idle cycles expected >=1", idle); end
        b0.mem_rdata = ~e.addr; b0.mem_resp = 1;
        #1;
        checks++; if ({b0.data_resp, b0.inst_resp} !== {e.is_data, ~e.is_data}) begin errors++; $display("FAIL rr_resp: got %b expected %b", {b0.data_resp, b0.inst_resp}, {e.is_data, ~e.is_data}); end
        tick();
        b0.mem_resp = 0;
        idle = b0.busy ? 0 : 1;
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_timeout: got %0d pending expected 0", sb.size()); end
    sb.delete();
    b0.inst_read = 0; b0.data_read = 0;
    tick();
  endtask

  task automatic test_fixed_priority;
    exp_t e;
    int served, budget;
    b1.inst_addr = 32'h44; b1.data_addr = 32'h88; b1.inst_read = 1; b1.data_read = 1;
    sb.push_back('{1'b1, 32'h88}); sb.push_back('{1'b1, 32'h88});
    sb.push_back('{1'b1, 32'h88}); sb.push_back('{1'b0, 32'h44});
    served = 0; budget = 0;
    while (sb.size() > 0 && budget < 60) begin
      tick(); budget++;
      if (b1.busy) begin
        e = sb.pop_front();
        checks++; if (b1.mem_addr !== e.addr) begin errors++; $display("FAIL fp_order: got %h expected %h", b1.mem_addr, e.addr); end
        b1.mem_resp = 1;
        #1;
        checks++; if ({b1.data_resp, b1.inst_resp} !== {e.is_data, ~e.is_data}) begin errors++; $display("FAIL fp_resp: got %b expected %b", {b1.data_resp, b1.inst_resp}, {e.is_data, ~e.is_data}); end
        tick();
        b1.mem_resp = 0;
        if (e.is_data) served++;
        if (served == 3) b1.data_read = 0;
        if (!e.is_data) b1.inst_read = 0;
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fp_timeout: got %0d pending expected 0", sb.size()); end
    sb.delete();
    b1.inst_read = 0; b1.data_read = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    b0.data_addr = 32'h400; b0.data_read = 1;
    tick();
    checks++; if ({b0.mem_read, b0.busy} !== 2'b11) begin errors++; $display("FAIL rm_setup: got %b expected 11", {b0.mem_read, b0.busy}); end
    rst = 1; b0.data_read = 0;
    tick();
    rst = 0;
    checks++; if ({b0.mem_read, b0.mem_write, b0.busy} !== 3'b000) begin errors++; $display("FAIL rm_abort: got %b expected 000", {b0.mem_read, b0.mem_write, b0.busy}); end
    b0.mem_resp = 1;
    #1;
    checks++; if ({b0.data_resp, b0.inst_resp} !== 2'b00) begin errors++; $display("FAIL rm_late_resp: got %b expected 00", {b0.data_resp, b0.inst_resp}); end
    tick();
    b0.mem_resp = 0;
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", b0.busy); end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_mid_request();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit main-memory port between the CPU instruction-fetch requester and the data load/store requester.
- Sits between the cpu core's inst_*/data_* interfaces and the single mm/cache-side port.
- Serves one outstanding transaction at a time. Downstream command signals are registered.
- Grant policy is round-robin or fixed data priority, selected by parameter.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; MBE width is DATA_WIDTH/8.
- ARB_POLICY, 0, 0 = round-robin between inst and data; 1 = data always wins ties.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_read  in  1  instruction read request, held until inst_resp
- inst_addr  in  ADDR_WIDTH  instruction address
- inst_resp  out  1  one-cycle completion pulse to inst requester
- inst_rdata  out  DATA_WIDTH  read data, valid when inst_resp
- data_read  in  1  data read request, held until data_resp
- data_write  in  1  data write request, held until data_resp
- data_mbe  in  DATA_WIDTH/8  write byte enables
- data_addr  in  ADDR_WIDTH  data address
- data_wdata  in  DATA_WIDTH  write data
- data_resp  out  1  one-cycle completion pulse to data requester
- data_rdata  out  DATA_WIDTH  read data, valid when data_resp
- mem_read  out  1  downstream read command
- mem_write  out  1  downstream write command
- mem_mbe  out  DATA_WIDTH/8  downstream byte enables
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data
- busy  out  1  high while a transaction is outstanding

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- FSM states: IDLE, INST, DATA.
- Reset values:
  - state = IDLE; last_grant = INST, so the first tie under round-robin goes to data.
  - mem_read, mem_write, busy, inst_resp, data_resp = 0.
  - mem_mbe, mem_addr, mem_wdata = 0.
- IDLE, one requester active: sample that request at the edge. Next cycle: state = INST or DATA, busy = 1, mem command registered.
  - Inst grant: mem_read = 1, mem_addr = inst_addr, mem_mbe = all ones.
  - Data grant: mem_read/mem_write = data_read/data_write, plus mem_addr, mem_mbe and mem_wdata captured.
- IDLE, both requesters active:
  - ARB_POLICY = 0: grant the requester not in last_grant.
  - ARB_POLICY = 1: grant data.
  - last_grant updates on every grant.
- data_read and data_write both high is illegal. Write takes precedence; a simulation assertion fires.
- Request to command latency: 1 cycle. Commands hold stable until mem_resp.
- INST or DATA with mem_resp = 1, same cycle:
  - The granted requester's resp = 1 (combinational from mem_resp and state).
  - Its rdata = mem_rdata (pass-through). The other resp stays 0.
- Next edge after mem_resp: state = IDLE; mem_read, mem_write, busy = 0.
  - A new grant takes at least one IDLE cycle, so the turnaround is 1 idle cycle minimum.
  - The requester deasserts or re-requests in the cycle after resp. The arbiter re-evaluates in IDLE.
- mem_resp in IDLE is ignored; no resp is generated.
- While busy, the other requester's request waits. It is not dropped, since requesters hold requests.
- Requester dropping its request before resp is illegal. The arbiter still completes the downstream transaction and pulses resp.
- Reset mid-transaction: next cycle is IDLE with all commands deasserted. A later mem_resp for the aborted access is ignored.
- inst_rdata and data_rdata equal mem_rdata at all times; they are meaningful only with their resp.
- Starvation bound (ARB_POLICY = 0): a continuously asserted request is granted within 2 transactions.

Test Plan:
- Reset, then inst_read=1 with inst_addr=0x60 → next cycle mem_read=1, mem_addr=0x60, mem_mbe=4'hF, busy=1. mem_resp=1 with mem_rdata=0x00000013 → inst_resp=1, inst_rdata=0x13 same cycle, data_resp=0. Next cycle mem_read=0, busy=0.
- data_write=1, data_addr=0x100, data_wdata=0xDEADBEEF, data_mbe=4'b0011 → mem_write=1 with identical fields and mem_read=0. mem_resp after 5 cycles → data_resp pulses exactly once, for 1 cycle.
- ARB_POLICY=0, inst and data both held continuously → grant order after reset is data, inst, data, inst. Each grant is followed by ≥1 IDLE cycle.
- ARB_POLICY=1, both held → data granted every time; inst waits while data stays asserted.
- Data grant active, inst_read raised mid-transaction → mem_addr does not change before mem_resp; inst is granted in the first IDLE after data_resp.
- rst=1 while state=DATA awaiting mem_resp → next cycle mem_read=mem_write=0, busy=0. mem_resp arriving afterwards causes no data_resp.
